imem_loadable: RTL
==================

# imem_loadable

Parametrised, loadable instruction memory for the MIPS pipelined CPU's IF stage. It replaces the reset-preloaded combinational ROM with a byte-addressed RAM and a registered fetch port that honours pipeline stall and flush. A byte-serial loader port with valid/ready handshake writes programs at runtime. A two-state FSM arbitrates between loading and fetching.

## Interface
Parameters:
- WORD_LEN, 32: instruction width in bits; must be a multiple of CELL_W.
- CELL_W, 8: memory cell (byte) width.
- MEM_BYTES, 1024: memory size in cells; power of two, at least WORD_LEN/CELL_W.
- BIG_ENDIAN, 1: 1 places the cell at the lowest address in the MSBs; 0 places it in the LSBs.
- NOP_WORD, 32'h0000_0000: value driven on `instruction` whenever it is not valid.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous reset, active-low.
- load_start  in  1  pulse; enters LOAD and clears the load pointer.
- load_valid  in  1  load byte present.
- load_data  in  CELL_W  load byte.
- load_last  in  1  qualifies the final byte of the program.
- load_ready  out  1  high in LOAD.
- load_err  out  1  sticky overflow flag; cleared by load_start or reset.
- fetch_req  in  1  fetch request from IF.
- fetch_addr  in  WORD_LEN  byte address (PC).
- stall  in  1  hold the current output.
- flush  in  1  kill the current and accepted fetch.
- instruction  out  WORD_LEN  fetched word.
- instr_valid  out  1  `instruction` is valid.
- fetch_fault  out  1  misaligned fetch; see Configuration.

## Operation
- FSM states are RUN and LOAD. Reset enters RUN. The memory array is not reset and its contents are undefined until loaded.
- RUN to LOAD: on load_start. LOAD to RUN: on an accepted byte with load_last=1, or on overflow.
- load_start in LOAD restarts the load: pointer goes to 0 and load_err is cleared.
- In LOAD, a byte is accepted when load_valid && load_ready. It is written to mem[ptr] and ptr increments.
- Overflow: a byte accepted at ptr==MEM_BYTES-1 with load_last=0 is written, the FSM returns to RUN, load_err is set to 1, and the pointer wraps to 0.
- Fetch is accepted when state==RUN && fetch_req && !stall && !flush.
  - The byte index is fetch_addr mod MEM_BYTES.
  - The word is assembled from WORD_LEN/CELL_W consecutive cells, ordered per BIG_ENDIAN.
  - Cell index arithmetic wraps modulo MEM_BYTES.
- stall=1: instruction, instr_valid and fetch_fault all hold.
- flush=1: priority over stall and fetch_req. Next cycle instr_valid=0, instruction=NOP_WORD, fetch_fault=0.
- No fetch accepted (and no stall): next cycle instr_valid=0, instruction=NOP_WORD.
- In LOAD, fetch_req is ignored and instr_valid=0. Entering LOAD invalidates the output on the following cycle regardless of stall.
- Read-during-write is not possible, because loading and fetching are mutually exclusive.

## Timing
- Reset values: state=RUN, ptr=0, load_ready=0, load_err=0, instr_valid=0, instruction=NOP_WORD, fetch_fault=0.
- Reset assertion mid-load aborts the load immediately. Bytes already written are retained.
- Fetch latency is 1 cycle: address accepted at edge N, output valid after edge N+1.
- Back-to-back fetches sustain one instruction per cycle.
- Loader throughput is one byte per cycle.
- load_ready rises the cycle after load_start and falls the cycle after the last byte is accepted.
- load_start and fetch_req in the same RUN cycle: load wins, the fetch is dropped, and instr_valid=0 next cycle.

## Configuration
- IMEM_MISALIGN_TRAP_EN defined: a fetch with fetch_addr[log2(WORD_LEN/CELL_W)-1:0]!=0 is accepted, but the next cycle gives instruction=NOP_WORD, instr_valid=0, fetch_fault=1. fetch_fault holds under stall.
- Not defined: the low alignment bits are forced to 0, the word is fetched normally, and fetch_fault is tied to 0.

## Structure
- Package imem_pkg holds:
  - the state encoding (RUN, LOAD);
  - the default NOP_WORD;
  - the helper constant CELLS_PER_WORD = WORD_LEN/CELL_W;
  - the pointer width $clog2(MEM_BYTES).
- Sub-module imem_cell_ram: a single-write-port, CELLS_PER_WORD-read-lane cell array with synchronous write and combinational read. The top level holds the FSM, pointer, output registers and endian assembly.

## Test plan
- Reset then load bytes 8'h20,8'h08,8'h00,8'h05 (last on the 4th), then fetch addr 0 -> one cycle later instruction=32'h2008_0005, instr_valid=1. With BIG_ENDIAN=0 -> 32'h0500_0820.
- Load 8 bytes and fetch 0, 4, 0, 4 on consecutive cycles -> four valid words, one per cycle. Assert stall on the 2nd output -> that word holds for the stall duration.
- Fetch in flight with flush=1 and stall=1 together -> next cycle instr_valid=0, instruction=32'h0.
- With MEM_BYTES=16, stream 17 bytes without load_last -> load_err=1 after the 16th byte, FSM in RUN, 17th byte not accepted (load_ready=0).
- Fetch addr 32'h2 -> with IMEM_MISALIGN_TRAP_EN: fetch_fault=1, instr_valid=0. Without it: word at addr 0 returned with instr_valid=1.
- Drop rst low mid-load after 2 bytes -> all outputs at reset values asynchronously. After release, a fetch of addr 0 returns the 2 new bytes with the remaining bytes unchanged from before the load.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and sizing helpers for the loadable instruction memory.
// Used by imem_cell_ram and imem_loadable.
package imem_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } imem_state_e;

  localparam int DEF_WORD_LEN  = 32;
  localparam int DEF_CELL_W    = 8;
  localparam int DEF_MEM_BYTES = 1024;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

  function automatic int cells_per_word(input int word_len, input int cell_w);
    return word_len / cell_w;
  endfunction

  function automatic int ptr_width(input int mem_bytes);
    return (mem_bytes > 1) ? $clog2(mem_bytes) : 1;
  endfunction

endpackage

// File: rtl/imem_cell_ram.sv
// Cell array with one synchronous write port and LANES combinational read
// lanes at consecutive cell indices, wrapping modulo the array size.
module imem_cell_ram
  import imem_pkg::*;
#(
  parameter int CELL_W    = DEF_CELL_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int LANES     = 4,
  parameter int PTR_W     = ptr_width(DEF_MEM_BYTES)
)(
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [PTR_W-1:0]        i_waddr,
  input  logic [CELL_W-1:0]       i_wdata,
  input  logic [PTR_W-1:0]        i_rbase,
  output logic [LANES*CELL_W-1:0] o_rlanes
);

  logic [CELL_W-1:0] r_mem [MEM_BYTES];

  // Contents are intentionally not reset: a reset mid-load keeps written cells.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PTR_W-1:0] w_idx;
      assign w_idx = i_rbase + PTR_W'(gi);
      assign o_rlanes[gi*CELL_W +: CELL_W] = r_mem[w_idx];
    end
  endgenerate

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: byte-serial loader plus registered fetch port.
// Optional macro IMEM_MISALIGN_TRAP_EN turns misaligned fetches into faults.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int WORD_LEN  = DEF_WORD_LEN,
  parameter int CELL_W    = DEF_CELL_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int BIG_ENDIAN = 1,
  parameter logic [WORD_LEN-1:0] NOP_WORD = WORD_LEN'(DEF_NOP_WORD)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [CELL_W-1:0]   load_data,
  input  logic                load_last,
  output logic                load_ready,
  output logic                load_err,
  input  logic                fetch_req,
  input  logic [WORD_LEN-1:0] fetch_addr,
  input  logic                stall,
  input  logic                flush,
  output logic [WORD_LEN-1:0] instruction,
  output logic                instr_valid,
  output logic                fetch_fault
);

  localparam int CELLS_PER_WORD = cells_per_word(WORD_LEN, CELL_W);
  localparam int PTR_W          = ptr_width(MEM_BYTES);
  localparam logic [PTR_W-1:0] ALIGN_MASK = PTR_W'(CELLS_PER_WORD - 1);

  imem_state_e         r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_load_err;
  logic                r_valid;
  logic [WORD_LEN-1:0] r_instr;

  logic                w_accept_byte;
  logic                w_last_cell;
  logic                w_fetch_go;
  logic                w_misalign;
  logic [PTR_W-1:0]    w_addr_idx;
  logic [PTR_W-1:0]    w_rbase;
  logic [WORD_LEN-1:0] w_lanes;
  logic [WORD_LEN-1:0] w_word;

  // load_start has priority, so a byte presented with it is not written.
  assign w_accept_byte = (r_state == LOAD) && load_valid && !load_start;
  assign w_last_cell   = (r_ptr == PTR_W'(MEM_BYTES - 1));
  assign w_fetch_go    = (r_state == RUN) && fetch_req && !stall && !flush && !load_start;
  assign w_addr_idx    = fetch_addr[PTR_W-1:0];

  generate
    if (PTR_W < WORD_LEN) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^fetch_addr[WORD_LEN-1:PTR_W];
    end
  endgenerate

`ifdef IMEM_MISALIGN_TRAP_EN
  assign w_misalign = |(w_addr_idx & ALIGN_MASK);
  assign w_rbase    = w_addr_idx;
`else
  assign w_misalign = 1'b0;
  assign w_rbase    = w_addr_idx & ~ALIGN_MASK;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_ptr      <= '0;
      r_load_err <= 1'b0;
    end else if (load_start) begin
      r_state    <= LOAD;
      r_ptr      <= '0;
      r_load_err <= 1'b0;
    end else if (w_accept_byte) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (load_last) begin
        r_state <= RUN;
      end else if (w_last_cell) begin
        r_state    <= RUN;
        r_load_err <= 1'b1;
      end
    end
  end

  imem_cell_ram #(
    .CELL_W    (CELL_W),
    .MEM_BYTES (MEM_BYTES),
    .LANES     (CELLS_PER_WORD),
    .PTR_W     (PTR_W)
  ) u_ram (
    .clk      (clk),
    .i_we     (w_accept_byte),
    .i_waddr  (r_ptr),
    .i_wdata  (load_data),
    .i_rbase  (w_rbase),
    .o_rlanes (w_lanes)
  );

  genvar gi;
  generate
    for (gi = 0; gi < CELLS_PER_WORD; gi++) begin : g_asm
      if (BIG_ENDIAN != 0) begin : g_be
        assign w_word[(CELLS_PER_WORD-1-gi)*CELL_W +: CELL_W] = w_lanes[gi*CELL_W +: CELL_W];
      end else begin : g_le
        assign w_word[gi*CELL_W +: CELL_W] = w_lanes[gi*CELL_W +: CELL_W];
      end
    end
  endgenerate

  // Flush and entry into LOAD override stall; stall otherwise freezes the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
    end else if (flush || load_start || r_state == LOAD) begin
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
    end else if (!stall) begin
      if (w_fetch_go && !w_misalign) begin
        r_valid <= 1'b1;
        r_instr <= w_word;
      end else begin
        r_valid <= 1'b0;
        r_instr <= NOP_WORD;
      end
    end
  end

`ifdef IMEM_MISALIGN_TRAP_EN
  logic r_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
    end else if (flush || load_start || r_state == LOAD) begin
      r_fault <= 1'b0;
    end else if (!stall) begin
      r_fault <= w_fetch_go && w_misalign;
    end
  end

  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

  assign load_ready  = (r_state == LOAD);
  assign load_err    = r_load_err;
  assign instruction = r_instr;
  assign instr_valid = r_valid;

endmodule
